dmem_io_unit: RTL and testbench



---
 rtl/dmem_io_pkg.sv | 19 +
 rtl/io_sync2.sv | 27 ++
 rtl/dmem_io_unit.sv | 136 +++++++++++++
 tb/tb_dmem_io_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_io_pkg.sv
// Shared constants for the data-memory / memory-mapped I/O unit:
// I/O register word offsets, STAT bit positions and the address-region type.
package dmem_io_pkg;

  localparam logic [1:0] IO_OUT  = 2'd0;
  localparam logic [1:0] IO_IN   = 2'd1;
  localparam logic [1:0] IO_CNT  = 2'd2;
  localparam logic [1:0] IO_STAT = 2'd3;

  localparam int STAT_CHG = 0;
  localparam int STAT_ERR = 1;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_NONE
  } region_e;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer that brings an asynchronous bus into the clock domain;
// both stages clear on the synchronous reset.
module io_sync2 #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dmem_io_unit.sv
// Data-side memory: word RAM plus a 4-register I/O window (OUT, IN, CNT, STAT).
// The CNT cycle counter is only built when DMEMIO_CYCLE_COUNTER_EN is defined.
module dmem_io_unit #(
  parameter int          DEPTH   = 128,
  parameter logic [15:0] IO_BASE = 16'hFFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic        bus_err
);
  import dmem_io_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   ram_q [DEPTH];
  logic [14:0]   word_idx;
  logic [AW-1:0] ram_idx;
  logic [1:0]    io_sel;
  logic          addr_lsb_unused;
  region_e       region;
  logic          io_wr;
  logic          ram_we;

  logic [15:0] gpio_sync;
  logic [15:0] sync_prev_q;
  logic [15:0] gpio_out_q, gpio_out_d;
  logic        chg_q, chg_d;
  logic        err_q, err_d;
  logic [15:0] cnt_val;

  assign word_idx        = dmemaddr[15:1];
  assign ram_idx         = word_idx[AW-1:0];
  assign io_sel          = dmemaddr[2:1];
  assign addr_lsb_unused = dmemaddr[0];

  // RAM takes priority; the I/O window is the 8-byte block containing IO_BASE.
  always_comb begin
    region = REGION_NONE;
    if ({17'd0, word_idx} < 32'(DEPTH)) begin
      region = REGION_RAM;
    end else if (dmemaddr[15:3] == IO_BASE[15:3]) begin
      region = REGION_IO;
    end
  end

  io_sync2 #(.WIDTH(16)) u_gpio_sync (
    .clock (clock),
    .reset (reset),
    .d     (gpio_in),
    .q     (gpio_sync)
  );

  always_comb begin
    dmemrdata = '0;
    unique case (region)
      REGION_RAM: dmemrdata = ram_q[ram_idx];
      REGION_IO: begin
        unique case (io_sel)
          IO_OUT:  dmemrdata = gpio_out_q;
          IO_IN:   dmemrdata = gpio_sync;
          IO_CNT:  dmemrdata = cnt_val;
          IO_STAT: begin
            dmemrdata[STAT_CHG] = chg_q;
            dmemrdata[STAT_ERR] = err_q;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign io_wr  = dmemwrite && (region == REGION_IO);
  assign ram_we = dmemwrite && (region == REGION_RAM) && !reset;

  // A new synchronized edge outranks a same-cycle STAT read clear.
  always_comb begin
    gpio_out_d = gpio_out_q;
    if (io_wr && io_sel == IO_OUT) gpio_out_d = dmemwdata;

    chg_d = chg_q;
    if (dmemread && region == REGION_IO && io_sel == IO_STAT) chg_d = 1'b0;
    if (gpio_sync != sync_prev_q) chg_d = 1'b1;

    err_d = err_q;
    if (io_wr && io_sel == IO_STAT && dmemwdata[STAT_ERR]) err_d = 1'b0;
    if (region == REGION_NONE && (dmemread || dmemwrite)) err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gpio_out_q  <= '0;
      sync_prev_q <= '0;
      chg_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gpio_out_q  <= gpio_out_d;
      sync_prev_q <= gpio_sync;
      chg_q       <= chg_d;
      err_q       <= err_d;
    end
  end

  // RAM contents survive reset; only the write itself is blocked.
  always_ff @(posedge clock) begin
    if (ram_we) ram_q[ram_idx] <= dmemwdata;
  end

`ifdef DMEMIO_CYCLE_COUNTER_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (io_wr && io_sel == IO_CNT) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_val = cnt_q;
`else
  assign cnt_val = '0;
`endif

  assign gpio_out = gpio_out_q;
  assign bus_err  = err_q;

endmodule

// File: tb/tb_dmem_io_unit.sv
// Self-checking bench for dmem_io_unit: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_dmem_io_unit;

  localparam int DEPTH = 128;

`ifdef DMEMIO_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  dmem_io_unit #(.DEPTH(DEPTH), .IO_BASE(16'hFFF0)) dut (
    .clock     (clock),
    .reset     (reset),
    .dmemaddr  (dmemaddr),
    .dmemwdata (dmemwdata),
    .dmemwrite (dmemwrite),
    .dmemread  (dmemread),
    .dmemrdata (dmemrdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .bus_err   (bus_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic [15:0] exp_out;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  // Reference model state: RAM by word index, register contents, and the
  // history of gpio_in values seen at each clock edge (newest first).
  logic [15:0] m_ram [int];
  logic [15:0] m_out;
  logic [15:0] m_cnt;
  logic        m_chg;
  logic        m_err;
  logic [15:0] m_hist [$];

  function automatic vec_t mk(input logic [15:0] addr, input logic [15:0] wdata,
                              input logic we, input logic re, input logic chk_rd,
                              input logic [15:0] exp_rd, input logic [15:0] exp_out,
                              input logic exp_err);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.we = we; v.re = re;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_out = exp_out; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] wdata,
                               input logic we, input logic re);
    dmemaddr  = addr;
    dmemwdata = wdata;
    dmemwrite = we;
    dmemread  = re;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // 0 = RAM, 1 = I/O window, 2 = unmapped
  function automatic int region_of(input logic [15:0] a);
    if (int'(a) < 2 * DEPTH) return 0;
    if (a >= 16'hFFF0 && a <= 16'hFFF7) return 1;
    return 2;
  endfunction

  function automatic logic modelRead(input logic [15:0] a, output logic [15:0] v);
    int off;
    v = 16'h0000;
    case (region_of(a))
      0: begin
        if (!m_ram.exists(int'(a >> 1))) return 1'b0;
        v = m_ram[int'(a >> 1)];
      end
      1: begin
        off = (int'(a) - 'hFFF0) / 2;
        case (off)
          0: v = m_out;
          1: v = m_hist[1];
          2: v = m_cnt;
          default: v = {14'd0, m_err, m_chg};
        endcase
      end
      default: v = 16'h0000;
    endcase
    return 1'b1;
  endfunction

  // Called at a rising edge, before inputs change, to advance the model.
  task automatic modelEdge();
    int r;
    int off;
    r = region_of(dmemaddr);
    off = (int'(dmemaddr) - 'hFFF0) / 2;
    if (reset) begin
      m_out = 16'h0000;
      m_cnt = 16'h0000;
      m_chg = 1'b0;
      m_err = 1'b0;
      m_hist = {16'h0000, 16'h0000, 16'h0000};
      return;
    end
    if (m_hist[1] != m_hist[2]) m_chg = 1'b1;
    else if (dmemread && r == 1 && off == 3) m_chg = 1'b0;
    if (r == 2 && (dmemread || dmemwrite)) m_err = 1'b1;
    else if (dmemwrite && r == 1 && off == 3 && dmemwdata[1]) m_err = 1'b0;
    if (dmemwrite && r == 1 && off == 0) m_out = dmemwdata;
    if (CNT_EN) m_cnt = (dmemwrite && r == 1 && off == 2) ? 16'h0000 : m_cnt + 16'h0001;
    if (dmemwrite && r == 0) m_ram[int'(dmemaddr >> 1)] = dmemwdata;
    m_hist.push_front(gpio_in);
    void'(m_hist.pop_back());
  endtask

  initial begin
    logic [15:0] exp;

    vecs[0]  = mk(16'h0010, 16'h1234, 1, 0, 0, 16'h0000, 16'h0000, 0);
    vecs[1]  = mk(16'h0010, 16'h0000, 0, 1, 1, 16'h1234, 16'h0000, 0);
    vecs[2]  = mk(16'h0011, 16'h0000, 0, 1, 1, 16'h1234, 16'h0000, 0);
    vecs[3]  = mk(16'hFFF0, 16'hA5A5, 1, 0, 1, 16'h0000, 16'hA5A5, 0);
    vecs[4]  = mk(16'hFFF0, 16'h0000, 0, 1, 1, 16'hA5A5, 16'hA5A5, 0);
    vecs[5]  = mk(16'h8000, 16'h0000, 0, 1, 1, 16'h0000, 16'hA5A5, 1);
    vecs[6]  = mk(16'hFFF6, 16'h0000, 0, 0, 1, 16'h0002, 16'hA5A5, 1);
    vecs[7]  = mk(16'hFFF6, 16'h0002, 1, 0, 1, 16'h0002, 16'hA5A5, 0);
    vecs[8]  = mk(16'hFFF2, 16'hFFFF, 1, 0, 1, 16'h0000, 16'hA5A5, 0);
    vecs[9]  = mk(16'h00FE, 16'hBEEF, 1, 0, 0, 16'h0000, 16'hA5A5, 0);
    vecs[10] = mk(16'h00FF, 16'h0000, 0, 1, 1, 16'hBEEF, 16'hA5A5, 0);
    vecs[11] = mk(16'h0100, 16'h0000, 0, 0, 1, 16'h0000, 16'hA5A5, 0);
    vecs[12] = mk(16'h0100, 16'h1111, 1, 0, 1, 16'h0000, 16'hA5A5, 1);
    vecs[13] = mk(16'hFFF6, 16'h0002, 1, 1, 1, 16'h0002, 16'hA5A5, 0);
    vecs[14] = mk(16'hFFF4, 16'h0000, 1, 0, 0, 16'h0000, 16'hA5A5, 0);
    vecs[15] = mk(16'hFFF8, 16'h0000, 0, 1, 1, 16'h0000, 16'hA5A5, 1);
    vecs[16] = mk(16'h0010, 16'h5678, 1, 1, 1, 16'h1234, 16'hA5A5, 1);
    vecs[17] = mk(16'h0010, 16'h0000, 0, 1, 1, 16'h5678, 16'hA5A5, 1);

    reset   = 1'b1;
    gpio_in = 16'h0000;
    applyStimulus(16'h0000, 16'h0000, 0, 0);
    tick();
    tick();
    checkOutput("reset_gpio_out", gpio_out, 16'h0000);
    checkOutput("reset_bus_err", {15'd0, bus_err}, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re);
      #1;
      if (vecs[i].chk_rd) checkOutput($sformatf("vec%0d_rdata", i), dmemrdata, vecs[i].exp_rd);
      tick();
      checkOutput($sformatf("vec%0d_gpio_out", i), gpio_out, vecs[i].exp_out);
      checkOutput($sformatf("vec%0d_bus_err", i), {15'd0, bus_err}, {15'd0, vecs[i].exp_err});
    end

    // Stores during reset are discarded for both registers and RAM.
    reset = 1'b1;
    applyStimulus(16'hFFF0, 16'h1234, 1, 0);
    tick();
    checkOutput("reset_store_gpio_out", gpio_out, 16'h0000);
    applyStimulus(16'h0010, 16'h9999, 1, 0);
    tick();
    reset = 1'b0;
    applyStimulus(16'h0010, 16'h0000, 0, 1);
    #1;
    checkOutput("reset_ram_store_blocked", dmemrdata, 16'h5678);
    tick();

    // gpio_in edge: visible on IN after two edges, flag after the third.
    applyStimulus(16'hFFF2, 16'h0000, 0, 0);
    gpio_in = 16'h00FF;
    tick();
    checkOutput("sync_not_early", dmemrdata, 16'h0000);
    tick();
    checkOutput("sync_latency", dmemrdata, 16'h00FF);
    applyStimulus(16'hFFF6, 16'h0000, 0, 0);
    #1;
    checkOutput("chg_not_early", dmemrdata, 16'h0000);
    tick();
    checkOutput("chg_set", dmemrdata, 16'h0001);
    applyStimulus(16'hFFF6, 16'h0000, 0, 1);
    tick();
    applyStimulus(16'hFFF6, 16'h0000, 0, 0);
    #1;
    checkOutput("chg_read_clear", dmemrdata, 16'h0000);

    // Read-clear in the same cycle a new change reaches the flag.
    gpio_in = 16'h0F0F;
    tick();
    tick();
    applyStimulus(16'hFFF6, 16'h0000, 0, 1);
    tick();
    applyStimulus(16'hFFF6, 16'h0000, 0, 0);
    #1;
    checkOutput("chg_set_wins", dmemrdata, 16'h0001);

`ifdef DMEMIO_CYCLE_COUNTER_EN
    reset = 1'b1;
    applyStimulus(16'hFFF4, 16'h0000, 0, 0);
    tick();
    reset = 1'b0;
    repeat (10) tick();
    checkOutput("cnt_after_10", dmemrdata, 16'd10);
    applyStimulus(16'hFFF4, 16'h7777, 1, 0);
    tick();
    applyStimulus(16'hFFF4, 16'h0000, 0, 0);
    checkOutput("cnt_clear", dmemrdata, 16'd0);
    tick();
    checkOutput("cnt_after_clear", dmemrdata, 16'd1);
    repeat (65534) tick();
    checkOutput("cnt_max", dmemrdata, 16'hFFFF);
    tick();
    checkOutput("cnt_wrap", dmemrdata, 16'h0000);
`else
    applyStimulus(16'hFFF4, 16'h7777, 1, 1);
    #1;
    checkOutput("cnt_absent_read", dmemrdata, 16'h0000);
    tick();
    applyStimulus(16'hFFF4, 16'h0000, 0, 0);
    #1;
    checkOutput("cnt_absent_after_write", dmemrdata, 16'h0000);
    checkOutput("cnt_absent_no_err", {15'd0, bus_err}, 16'h0000);
`endif

    // Randomized traffic against the reference model.
    reset = 1'b1;
    applyStimulus(16'h0000, 16'h0000, 0, 0);
    @(posedge clock);
    modelEdge();
    #1;
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 5)      dmemaddr = 16'($urandom_range(0, 2 * DEPTH - 1));
      else if (kind < 8) dmemaddr = 16'(32'hFFF0 + $urandom_range(0, 7));
      else               dmemaddr = 16'($urandom_range(2 * DEPTH, 32'hFFEF));
      dmemwdata = 16'($urandom);
      dmemwrite = ($urandom_range(0, 2) == 0);
      dmemread  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) gpio_in = 16'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      #1;
      if (modelRead(dmemaddr, exp)) checkOutput("rand_rdata", dmemrdata, exp);
      @(posedge clock);
      modelEdge();
      #1;
      checkOutput("rand_gpio_out", gpio_out, m_out);
      checkOutput("rand_bus_err", {15'd0, bus_err}, {15'd0, m_err});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
